// File: rtl/wdt_sleep_ctrl.sv
// Watchdog timer and SLEEP/CLRWDT sequencer for the PIC16C57 core.
// It counts instruction cycles through an optional prescaler, freezes the
// core while asleep, requests a core reset on timeout and keeps the STATUS
// TO/PD bits.
module wdt_sleep_ctrl #(
  parameter int WDT_WIDTH  = 8,
  parameter int RST_CYCLES = 4,
  parameter int SLEEP_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 q4_tick,
  input  logic                 clrwdt_exec,
  input  logic                 sleep_exec,
  input  logic                 option_wr,
  input  logic [3:0]           option_in,
  input  logic                 wdt_en,
  output logic                 core_hold,
  output logic                 wdt_reset_req,
  output logic                 to_n,
  output logic                 pd_n,
  output logic [WDT_WIDTH-1:0] wdt_count
);

  localparam int DIV_W = (SLEEP_DIV > 1) ? $clog2(SLEEP_DIV) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEEP_DIV - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SLEEP,
    ST_RESET_REQ
  } state_e;

  state_e               state_q, state_d;
  logic [WDT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           presc_q, presc_d;
  logic                 psa_q, psa_d;
  logic [2:0]           ps_q, ps_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [RC_W-1:0]      rcnt_q, rcnt_d;
  logic                 to_n_q, to_n_d;
  logic                 pd_n_q, pd_n_d;

  // Datapath view of the counters before any FSM override.
  logic                 tick;
  logic                 cnt_inc;
  logic                 timeout;
  logic [7:0]           presc_mask;
  logic [7:0]           presc_tick;
  logic [WDT_WIDTH-1:0] cnt_tick;

  // State register: all control and counter state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments make every register update at the edge
    // from the old values, independent of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      presc_q <= '0;
      psa_q   <= 1'b1;
      ps_q    <= 3'b111;
      div_q   <= '0;
      rcnt_q  <= '0;
      to_n_q  <= 1'b1;
      pd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      psa_q   <= psa_d;
      ps_q    <= ps_d;
      div_q   <= div_d;
      rcnt_q  <= rcnt_d;
      to_n_q  <= to_n_d;
      pd_n_q  <= pd_n_d;
    end
  end

  // Tick source selection and prescaler / base counter advance.
  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    tick       = 1'b0;
    cnt_inc    = 1'b0;
    presc_tick = presc_q;
    presc_mask = (8'd1 << ps_q) - 8'd1;
    unique case (state_q)
      ST_RUN:   tick = q4_tick;
      ST_SLEEP: tick = (div_q == DIV_LAST);
      default:  tick = 1'b0;
    endcase
    if (tick && wdt_en) begin
      if (psa_q) begin
        if (presc_q == presc_mask) begin
          presc_tick = '0;
          cnt_inc    = 1'b1;
        end else begin
          presc_tick = presc_q + 8'd1;
        end
      end else begin
        cnt_inc = 1'b1;
      end
    end
    cnt_tick = cnt_inc ? cnt_q + WDT_WIDTH'(1) : cnt_q;
    timeout  = cnt_inc && (&cnt_q);
  end

  // Next-state logic; in RUN: sleep > clrwdt > timeout, option_wr always applies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_tick;
    presc_d = presc_tick;
    psa_d   = psa_q;
    ps_d    = ps_q;
    div_d   = div_q;
    rcnt_d  = rcnt_q;
    to_n_d  = to_n_q;
    pd_n_d  = pd_n_q;
    unique case (state_q)
      ST_RUN: begin
        div_d  = '0;
        rcnt_d = '0;
        if (sleep_exec) begin
          state_d = ST_SLEEP;
          cnt_d   = '0;
          presc_d = '0;
          to_n_d  = 1'b1;
          pd_n_d  = 1'b0;
        end else if (clrwdt_exec) begin
          cnt_d   = '0;
          presc_d = '0;
          to_n_d  = 1'b1;
          pd_n_d  = 1'b1;
        end else if (timeout) begin
          state_d = ST_RESET_REQ;
          to_n_d  = 1'b0;
          pd_n_d  = 1'b1;
        end
        if (option_wr) begin
          psa_d   = option_in[3];
          ps_d    = option_in[2:0];
          presc_d = '0;
        end
      end
      ST_SLEEP: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (timeout) begin
          state_d = ST_RESET_REQ;
          div_d   = '0;
          rcnt_d  = '0;
          to_n_d  = 1'b0;
          pd_n_d  = 1'b0;
        end
      end
      ST_RESET_REQ: begin
        if (rcnt_q == RC_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          presc_d = '0;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    core_hold     = (state_q == ST_SLEEP);
    wdt_reset_req = (state_q == ST_RESET_REQ);
    to_n          = to_n_q;
    pd_n          = pd_n_q;
    wdt_count     = cnt_q;
  end

endmodule

// File: tb/tb_wdt_sleep_ctrl.sv
// Scoreboard bench for wdt_sleep_ctrl: directed stimulus pushes expected
// output snapshots and reset-pulse widths; monitors pop and compare them.
module tb_wdt_sleep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       q4_tick, clrwdt_exec, sleep_exec, option_wr, wdt_en;
  logic [3:0] option_in;
  logic       core_hold, wdt_reset_req, to_n, pd_n;
  logic [7:0] wdt_count;

  wdt_sleep_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .q4_tick      (q4_tick),
    .clrwdt_exec  (clrwdt_exec),
    .sleep_exec   (sleep_exec),
    .option_wr    (option_wr),
    .option_in    (option_in),
    .wdt_en       (wdt_en),
    .core_hold    (core_hold),
    .wdt_reset_req(wdt_reset_req),
    .to_n         (to_n),
    .pd_n         (pd_n),
    .wdt_count    (wdt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cnt;
    bit    hold;
    bit    rreq;
    bit    to_n;
    bit    pd_n;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pw       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic expect_out(input string name, input int cnt, input bit hold,
                            input bit rreq, input bit to_e, input bit pd_e);
    exp_t e;
    e.name = name; e.cnt = cnt; e.hold = hold;
    e.rreq = rreq; e.to_n = to_e; e.pd_n = pd_e;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      q4_tick = 1'b1; cyc();
      q4_tick = 1'b0; cyc(); cyc(); cyc();
    end
  endtask

  // Final tick that wraps the counter; reset request follows immediately.
  task automatic timeout_tick(input string name, input bit pd_e);
    pulse_q.push_back(4);
    q4_tick = 1'b1; cyc();
    q4_tick = 1'b0;
    expect_out({name, ".wrap"}, 0, 1'b0, 1'b1, 1'b0, pd_e);
    repeat (4) cyc();
    expect_out({name, ".after"}, 0, 1'b0, 1'b0, 1'b0, pd_e);
  endtask

  // Snapshot monitor: compares queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".count"}, 32'(wdt_count),     32'(e.cnt));
        check({e.name, ".hold"},  32'(core_hold),     32'(e.hold));
        check({e.name, ".rreq"},  32'(wdt_reset_req), 32'(e.rreq));
        check({e.name, ".to_n"},  32'(to_n),          32'(e.to_n));
        check({e.name, ".pd_n"},  32'(pd_n),          32'(e.pd_n));
      end
    end
  end

  // Pulse monitor: measures every wdt_reset_req pulse when it ends.
  initial begin
    forever begin
      @(negedge clk);
      if (wdt_reset_req === 1'b1) begin
        pw++;
      end else if (pw > 0) begin
        if (pulse_q.size() == 0) check("rreq.unexpected_pulse", pw, 0);
        else check("rreq.width", pw, pulse_q.pop_front());
        pw = 0;
      end
    end
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL sim_time_bound: got expired, expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "time bound expired");
  end

  initial begin
    rst = 1'b1; q4_tick = 1'b0; clrwdt_exec = 1'b0; sleep_exec = 1'b0;
    option_wr = 1'b0; option_in = 4'b0000; wdt_en = 1'b1;
    repeat (2) cyc();
    expect_out("reset", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    rst = 1'b0;

    // 1: PSA=0, timeout on the 256th tick
    option_in = 4'b0000; option_wr = 1'b1; cyc(); option_wr = 1'b0;
    send_ticks(255);
    expect_out("t1.255", 255, 1'b0, 1'b0, 1'b1, 1'b1);
    timeout_tick("t1", 1'b1);

    // 2: PSA=1 PS=2, count every 4th tick, timeout on tick 1024
    option_in = 4'b1010; option_wr = 1'b1; cyc(); option_wr = 1'b0;
    send_ticks(8);
    expect_out("t2.8", 2, 1'b0, 1'b0, 1'b0, 1'b1);
    send_ticks(1015);
    expect_out("t2.1023", 255, 1'b0, 1'b0, 1'b0, 1'b1);
    timeout_tick("t2", 1'b1);

    // 3: CLRWDT clears, and cancels a coincident timeout
    option_in = 4'b0000; option_wr = 1'b1; cyc(); option_wr = 1'b0;
    send_ticks(200);
    expect_out("t3.200", 200, 1'b0, 1'b0, 1'b0, 1'b1);
    clrwdt_exec = 1'b1; cyc(); clrwdt_exec = 1'b0;
    expect_out("t3.clr", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_ticks(255);
    expect_out("t3.255", 255, 1'b0, 1'b0, 1'b1, 1'b1);
    q4_tick = 1'b1; clrwdt_exec = 1'b1; cyc();
    q4_tick = 1'b0; clrwdt_exec = 1'b0;
    expect_out("t3.clr_vs_to", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (6) cyc();
    expect_out("t3.no_reset", 0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 4: SLEEP with internal tick; q4_tick, CLRWDT, OPTION ignored
    send_ticks(10);
    expect_out("t4.pre", 10, 1'b0, 1'b0, 1'b1, 1'b1);
    sleep_exec = 1'b1; cyc(); sleep_exec = 1'b0;
    expect_out("t4.enter", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    q4_tick = 1'b1;
    repeat (3) cyc();
    expect_out("t4.clk3", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    expect_out("t4.clk4", 1, 1'b1, 1'b0, 1'b1, 1'b0);
    q4_tick = 1'b0; clrwdt_exec = 1'b1; option_in = 4'b1111; option_wr = 1'b1;
    cyc();
    clrwdt_exec = 1'b0; option_wr = 1'b0;
    repeat (1015) cyc();
    expect_out("t4.clk1020", 255, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_q.push_back(4);
    repeat (4) cyc();
    expect_out("t4.wake", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc();
    expect_out("t4.run", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: wdt_en=0 sleeps forever; async reset aborts
    wdt_en = 1'b0;
    sleep_exec = 1'b1; cyc(); sleep_exec = 1'b0;
    expect_out("t5.enter", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5100) cyc();
    expect_out("t5.frozen", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    rst = 1'b1; #1;
    expect_out("t5.async_rst", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(); cyc();
    rst = 1'b0; wdt_en = 1'b1;

    // 6: sleep + clrwdt + timeout in one cycle
    option_in = 4'b0000; option_wr = 1'b1; cyc(); option_wr = 1'b0;
    send_ticks(255);
    expect_out("t6.255", 255, 1'b0, 1'b0, 1'b1, 1'b1);
    q4_tick = 1'b1; sleep_exec = 1'b1; clrwdt_exec = 1'b1; cyc();
    q4_tick = 1'b0; sleep_exec = 1'b0; clrwdt_exec = 1'b0;
    expect_out("t6.sleep", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc();
    expect_out("t6.hold", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20 && (exp_q.size() > 0 || pulse_q.size() > 0 || pw != 0); i++) cyc();
    cyc();
    if (exp_q.size() > 0) check("leftover.snapshots", exp_q.size(), 0);
    if (pulse_q.size() > 0) check("leftover.pulses", pulse_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wdt_sleep_ctrl.md
Name: wdt_sleep_ctrl

Overview:
Watchdog timer and SLEEP/CLRWDT sequencer for the PIC16C57 core, giving real behaviour to the CLRWDT, SLEEP and OPTION instructions, which currently execute as no-ops.
- Counts instruction cycles through an optional prescaler.
- Freezes the core during SLEEP.
- Requests a core reset on watchdog timeout.
- Supplies the STATUS TO/PD bits.
- Sits beside the CU; decoded Q4 execute strobes from the core drive its inputs.

Parameters:
- WDT_WIDTH, 8, width of the watchdog base counter; timeout on wrap from all-ones.
- RST_CYCLES, 4, length in clk cycles of the wdt_reset_req pulse.
- SLEEP_DIV, 4, clk cycles per internally generated tick while in SLEEP.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- q4_tick  in  1  one-clk pulse per instruction cycle (core EX Q4).
- clrwdt_exec  in  1  one-clk pulse: CLRWDT executing at Q4.
- sleep_exec  in  1  one-clk pulse: SLEEP executing at Q4.
- option_wr  in  1  one-clk pulse: OPTION executing; latch option_in.
- option_in  in  4  {PSA, PS[2:0]} taken from W bits [3:0].
- wdt_en  in  1  configuration fuse; 0 freezes the WDT.
- core_hold  out  1  freeze the core (CU and fetch) while asleep.
- wdt_reset_req  out  1  core reset request; the top level ORs it into the core reset.
- to_n  out  1  STATUS bit 4 (TO, active low).
- pd_n  out  1  STATUS bit 3 (PD, active low).
- wdt_count  out  WDT_WIDTH  base counter value, for debug and verification.

Behaviour:
Reset (asynchronous, clears all state):
- State RUN.
- wdt_count=0, prescaler=0, PSA=1, PS=3'b111, sleep divider=0.
- core_hold=0, wdt_reset_req=0, to_n=1, pd_n=1.

Tick source:
- RUN: tick = q4_tick.
- SLEEP: tick = internal pulse on every SLEEP_DIV-th clk. The divider restarts at 0 on SLEEP entry, so the first tick comes SLEEP_DIV clks after entry.
- RESET_REQ: no ticks.

Prescaler (8-bit):
- PSA=1: each tick increments the prescaler. When the prescaler equals (2^PS)-1, the tick wraps it to 0 and increments wdt_count, giving ratio 1:2^PS (1:1 to 1:128).
- PSA=0: each tick increments wdt_count directly; the prescaler stays at 0.
- option_wr: latch PSA/PS and clear the prescaler. wdt_count is not changed.

Timeout:
- A wdt_count increment from all-ones wraps it to 0 and raises timeout in that same cycle.
- wdt_en=0: counter and prescaler hold, and timeout never fires.

State machine (RUN, SLEEP, RESET_REQ), all transitions registered:
- RUN + sleep_exec: go to SLEEP. Clear wdt_count and prescaler; to_n=1, pd_n=0. core_hold=1 from the next edge.
- RUN + clrwdt_exec: clear wdt_count and prescaler; to_n=1, pd_n=1.
- RUN + timeout: go to RESET_REQ; to_n=0, pd_n=1.
- SLEEP + timeout: go to RESET_REQ; to_n=0, pd_n=0. core_hold drops on the same edge.
- SLEEP with wdt_en=0: remains in SLEEP until rst.
- RESET_REQ: wdt_reset_req=1 for exactly RST_CYCLES clks, then RUN with wdt_count=0 and prescaler=0. to_n/pd_n are retained, since only rst clears them.

Priority in RUN when events coincide in one cycle:
- sleep_exec > clrwdt_exec > timeout.
- Clearing the counter cancels a coincident timeout.
- option_wr coinciding with any of these is applied as well.

Other rules:
- clrwdt_exec, sleep_exec and option_wr are ignored in SLEEP and RESET_REQ.
- rst asserted mid-SLEEP or mid-RESET_REQ aborts at once to the reset values.
- Outputs are driven from registers only; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset; PSA=0 via option_wr; q4_tick every 4 clks → the 256th tick wraps wdt_count 255→0. wdt_reset_req is high next edge for 4 clks, then to_n=0, pd_n=1, state RUN.
2. option_in=4'b1010 (PSA=1, PS=2) → wdt_count increments every 4th tick; timeout on tick 1024.
3. PSA=0; clrwdt_exec at wdt_count=200 → count=0, to_n=1, pd_n=1, no reset. clrwdt_exec coinciding with the 256th tick → no timeout, count=0.
4. PSA=0; sleep_exec → core_hold=1, pd_n=0, to_n=1; q4_tick is ignored. After 256×4=1024 clks: core_hold=0, wdt_reset_req 4 clks, to_n=0, pd_n=0.
5. wdt_en=0; sleep_exec → core_hold stays 1 for more than 5000 clks with wdt_count frozen. Async rst mid-sleep → core_hold=0 and to_n=pd_n=1 without waiting for a clk edge.
6. sleep_exec and clrwdt_exec in the same cycle as a timeout → SLEEP entered, no wdt_reset_req, pd_n=0.
